// File: rtl/fault_sup_pkg.sv
// Shared types and helpers for the fault supervisor: FSM state and
// log-event encodings plus a saturating counter step.
package fault_sup_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_WARNING  = 2'd1,
        ST_FAULT    = 2'd2,
        ST_SHUTDOWN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        EVT_ENTER_WARN     = 2'd0,
        EVT_ENTER_FAULT    = 2'd1,
        EVT_ENTER_SHUTDOWN = 2'd2,
        EVT_MANUAL_RESET   = 2'd3
    } evt_e;

    // Entry counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fault_chan_debounce.sv
// One supervised channel: threshold compare and asymmetric debounce.
// The status needs DEB_ON consecutive faulty samples to rise and
// DEB_OFF consecutive clean samples to fall, which gives hysteresis.
module fault_chan_debounce
    import fault_sup_pkg::*;
#(
    parameter int ADC_WIDTH = 12,
    parameter int DEB_ON    = 8,
    parameter int DEB_OFF   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic [ADC_WIDTH-1:0] sample,
    input  logic [ADC_WIDTH-1:0] thresh,
    input  logic                 dir_under,
    output logic                 status
);

    localparam int ON_W  = $clog2(DEB_ON + 1);
    localparam int OFF_W = $clog2(DEB_OFF + 1);
    localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(DEB_ON - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(DEB_OFF - 1);
    localparam logic [ON_W-1:0]  ON_ONE   = ON_W'(1);
    localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);

    logic             raw;
    logic [ON_W-1:0]  on_cnt;
    logic [OFF_W-1:0] off_cnt;

    // Unsigned compare in the configured direction; equality is never a fault.
    always_comb begin
        raw = dir_under ? (sample < thresh) : (sample > thresh);
    end

    // Count consecutive qualifying samples toward whichever edge is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status  <= 1'b0;
            on_cnt  <= '0;
            off_cnt <= '0;
        end else if (sample_valid) begin
            if (!status) begin
                off_cnt <= '0;
                if (!raw) begin
                    on_cnt <= '0;
                end else if (on_cnt == ON_LAST) begin
                    on_cnt <= '0;
                    status <= 1'b1;
                end else begin
                    on_cnt <= on_cnt + ON_ONE;
                end
            end else begin
                on_cnt <= '0;
                if (raw) begin
                    off_cnt <= '0;
                end else if (off_cnt == OFF_LAST) begin
                    off_cnt <= '0;
                    status  <= 1'b0;
                end else begin
                    off_cnt <= off_cnt + OFF_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/fault_supervisor.sv
// Supervises NUM_CH ADC channels. It escalates NORMAL/WARNING/FAULT/SHUTDOWN
// on the debounced, unmasked channel status and logs every logged transition
// into a timestamped first-word-fall-through FIFO.
module fault_supervisor
    import fault_sup_pkg::*;
#(
    parameter int NUM_CH           = 8,
    parameter int ADC_WIDTH        = 12,
    parameter int DEB_ON           = 8,
    parameter int DEB_OFF          = 16,
    parameter int PERSIST_TO_FAULT = 50,
    parameter int LOG_DEPTH        = 16,
    parameter int TS_WIDTH         = 32,
    localparam int CH_W            = $clog2(NUM_CH),
    localparam int LOG_W           = TS_WIDTH + CH_W + 2,
    localparam int CNT_W           = $clog2(LOG_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    input  logic [NUM_CH*ADC_WIDTH-1:0] sample_packed,
    input  logic [NUM_CH*ADC_WIDTH-1:0] thresh_packed,
    input  logic [NUM_CH-1:0]           dir_under,
    input  logic [NUM_CH-1:0]           mask,
    input  logic [NUM_CH-1:0]           shutdown_en,
    input  logic                        manual_reset,
    output logic [1:0]                  state_o,
    output logic                        fault_latched_o,
    output logic [CH_W-1:0]             active_ch_o,
    output logic [NUM_CH-1:0]           chan_status_o,
    output logic [31:0]                 fault_count_o,
    output logic [31:0]                 warning_count_o,
    output logic                        log_valid_o,
    input  logic                        log_ready_i,
    output logic [LOG_W-1:0]            log_data_o,
    output logic                        log_overflow_o,
    output logic [CNT_W-1:0]            log_count_o
);

    localparam int AW     = $clog2(LOG_DEPTH);
    localparam int PERS_W = $clog2(PERSIST_TO_FAULT + 1);
    localparam logic [PERS_W-1:0]   PERS_LAST = PERS_W'(PERSIST_TO_FAULT - 1);
    localparam logic [PERS_W-1:0]   PERS_ONE  = PERS_W'(1);
    localparam logic [TS_WIDTH-1:0] TS_ONE    = TS_WIDTH'(1);
    localparam logic [AW-1:0]       PTR_ONE   = AW'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_FULL  = CNT_W'(LOG_DEPTH);

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [CH_W-1:0]     ch;
        evt_e                evt;
    } log_entry_t;

    logic [NUM_CH-1:0]   chan_status;
    logic [NUM_CH-1:0]   eff;
    logic [NUM_CH-1:0]   eff_sd;
    logic                any;
    logic [CH_W-1:0]     prio_ch;
    logic [CH_W-1:0]     sd_ch;

    state_e              state, state_next;
    logic [PERS_W-1:0]   persist, persist_next;
    logic [CH_W-1:0]     active_ch, active_next;
    logic                warn_inc, fault_inc;
    logic                push;
    evt_e                push_evt;
    logic [CH_W-1:0]     push_ch;
    logic [TS_WIDTH-1:0] ts;
    logic [31:0]         fault_count, warning_count;

    log_entry_t          mem [LOG_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic                pop, push_ok;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            fault_chan_debounce #(
                .ADC_WIDTH (ADC_WIDTH),
                .DEB_ON    (DEB_ON),
                .DEB_OFF   (DEB_OFF)
            ) u_deb (
                .clk          (clk),
                .rst          (rst),
                .sample_valid (sample_valid),
                .sample       (sample_packed[g*ADC_WIDTH +: ADC_WIDTH]),
                .thresh       (thresh_packed[g*ADC_WIDTH +: ADC_WIDTH]),
                .dir_under    (dir_under[g]),
                .status       (chan_status[g])
            );
        end
    endgenerate

    // Lowest-index active channel, overall and among shutdown-capable ones.
    always_comb begin
        eff     = chan_status & ~mask;
        eff_sd  = eff & shutdown_en;
        any     = |eff;
        prio_ch = '0;
        sd_ch   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eff[i])    prio_ch = CH_W'(i);
            if (eff_sd[i]) sd_ch   = CH_W'(i);
        end
    end

    // Next-state decision; manual_reset outside NORMAL overrides everything.
    always_comb begin
        state_next   = state;
        persist_next = persist;
        active_next  = active_ch;
        warn_inc     = 1'b0;
        fault_inc    = 1'b0;
        push         = 1'b0;
        push_evt     = EVT_ENTER_WARN;
        push_ch      = '0;
        if (state != ST_NORMAL && manual_reset) begin
            state_next   = ST_NORMAL;
            persist_next = '0;
            active_next  = '0;
            push         = 1'b1;
            push_evt     = EVT_MANUAL_RESET;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (any) begin
                        state_next   = ST_WARNING;
                        persist_next = '0;
                        warn_inc     = 1'b1;
                        push         = 1'b1;
                        push_evt     = EVT_ENTER_WARN;
                        push_ch      = prio_ch;
                    end
                end
                ST_WARNING: begin
                    if (any) begin
                        if (persist == PERS_LAST) begin
                            state_next  = ST_FAULT;
                            active_next = prio_ch;
                            fault_inc   = 1'b1;
                            push        = 1'b1;
                            push_evt    = EVT_ENTER_FAULT;
                            push_ch     = prio_ch;
                        end else begin
                            persist_next = persist + PERS_ONE;
                        end
                    end else if (persist == '0) begin
                        state_next = ST_NORMAL;
                    end else begin
                        persist_next = persist - PERS_ONE;
                    end
                end
                ST_FAULT: begin
                    if (eff_sd != '0) begin
                        state_next  = ST_SHUTDOWN;
                        active_next = sd_ch;
                        push        = 1'b1;
                        push_evt    = EVT_ENTER_SHUTDOWN;
                        push_ch     = sd_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, persistence, latched channel, entry counters and timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_NORMAL;
            persist       <= '0;
            active_ch     <= '0;
            fault_count   <= '0;
            warning_count <= '0;
            ts            <= '0;
        end else begin
            state   <= state_next;
            persist <= persist_next;
            active_ch <= active_next;
            ts      <= ts + TS_ONE;
            if (warn_inc)  warning_count <= sat_inc32(warning_count);
            if (fault_inc) fault_count   <= sat_inc32(fault_count);
        end
    end

    // A push into a full FIFO only fits if the head leaves on the same edge.
    always_comb begin
        pop     = (count != '0) && log_ready_i;
        push_ok = push && ((count != CNT_FULL) || pop);
    end

    // Event FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LOG_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{ts: ts, ch: push_ch, evt: push_evt};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !push_ok) overflow <= 1'b1;
            if (push_ok && !pop)      count <= count + CNT_ONE;
            else if (!push_ok && pop) count <= count - CNT_ONE;
        end
    end

    assign state_o         = state;
    assign fault_latched_o = (state == ST_FAULT) || (state == ST_SHUTDOWN);
    assign active_ch_o     = active_ch;
    assign chan_status_o   = chan_status;
    assign fault_count_o   = fault_count;
    assign warning_count_o = warning_count;
    assign log_valid_o     = (count != '0);
    assign log_data_o      = log_valid_o ? mem[rd_ptr] : '0;
    assign log_overflow_o  = overflow;
    assign log_count_o     = count;

endmodule

// File: tb/tb_fault_supervisor.sv
// Self-checking bench for fault_supervisor. Expected log entries go into a
// scoreboard queue as each transition is provoked and are compared as the
// FIFO is drained.
module tb_fault_supervisor;
    import fault_sup_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int ADC_WIDTH = 12;
    localparam int CH_W      = 3;
    localparam int TS_WIDTH  = 32;
    localparam int LOG_W     = TS_WIDTH + CH_W + 2;
    localparam int LOG_DEPTH = 16;
    localparam int PERSIST   = 50;

    logic                        clk;
    logic                        rst;
    logic                        sample_valid;
    logic [NUM_CH*ADC_WIDTH-1:0] sample_packed;
    logic [NUM_CH*ADC_WIDTH-1:0] thresh_packed;
    logic [NUM_CH-1:0]           dir_under;
    logic [NUM_CH-1:0]           mask;
    logic [NUM_CH-1:0]           shutdown_en;
    logic                        manual_reset;
    logic [1:0]                  state_o;
    logic                        fault_latched_o;
    logic [CH_W-1:0]             active_ch_o;
    logic [NUM_CH-1:0]           chan_status_o;
    logic [31:0]                 fault_count_o;
    logic [31:0]                 warning_count_o;
    logic                        log_valid_o;
    logic                        log_ready_i;
    logic [LOG_W-1:0]            log_data_o;
    logic                        log_overflow_o;
    logic [4:0]                  log_count_o;

    fault_supervisor #(
        .NUM_CH           (NUM_CH),
        .ADC_WIDTH        (ADC_WIDTH),
        .DEB_ON           (8),
        .DEB_OFF          (16),
        .PERSIST_TO_FAULT (PERSIST),
        .LOG_DEPTH        (LOG_DEPTH),
        .TS_WIDTH         (TS_WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_valid    (sample_valid),
        .sample_packed   (sample_packed),
        .thresh_packed   (thresh_packed),
        .dir_under       (dir_under),
        .mask            (mask),
        .shutdown_en     (shutdown_en),
        .manual_reset    (manual_reset),
        .state_o         (state_o),
        .fault_latched_o (fault_latched_o),
        .active_ch_o     (active_ch_o),
        .chan_status_o   (chan_status_o),
        .fault_count_o   (fault_count_o),
        .warning_count_o (warning_count_o),
        .log_valid_o     (log_valid_o),
        .log_ready_i     (log_ready_i),
        .log_data_o      (log_data_o),
        .log_overflow_o  (log_overflow_o),
        .log_count_o     (log_count_o)
    );

    int               n_checks;
    int               n_fail;
    int               exp_warn;
    int               exp_fault;
    logic [31:0]      edge_cnt;
    logic [LOG_W-1:0] sb_q[$];
    logic [LOG_W-1:0] popped[$];
    logic [LOG_W-1:0] head;

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset; an event logged on edge n carries stamp n-1.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= '0;
        else     edge_cnt <= edge_cnt + 32'd1;
    end

    // Hard stop in case something never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setSample(input int ch, input logic [ADC_WIDTH-1:0] value);
        sample_packed[ch*ADC_WIDTH +: ADC_WIDTH] = value;
    endtask

    // Present the current sample vector as n consecutive valid samples.
    task automatic applyStimulus(input int n);
        sample_valid = 1'b1;
        tick(n);
        sample_valid = 1'b0;
    endtask

    task automatic pushExp(input logic [1:0] evt, input logic [CH_W-1:0] ch);
        sb_q.push_back({edge_cnt - 32'd1, ch, evt});
    endtask

    // Pop every FIFO entry, comparing each against the scoreboard in order.
    task automatic drainLog(input string tag);
        popped.delete();
        log_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!log_valid_o) break;
            if (sb_q.size() == 0) begin
                checkOutput({tag, " unexpected_entry"}, 64'(sb_q.size()), 64'd1);
            end else begin
                head = sb_q.pop_front();
                checkOutput({tag, " entry"}, 64'(log_data_o), 64'(head));
            end
            popped.push_back(log_data_o);
            tick(1);
        end
        log_ready_i = 1'b0;
        checkOutput({tag, " drained"}, 64'(log_valid_o), 64'd0);
        checkOutput({tag, " sb_empty"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_warn      = 0;
        exp_fault     = 0;
        rst           = 1'b1;
        sample_valid  = 1'b0;
        thresh_packed = {NUM_CH{12'd2048}};
        sample_packed = {NUM_CH{12'd2048}};
        dir_under     = 8'b0000_0001;
        mask          = 8'b0000_1000;
        shutdown_en   = 8'b0000_0000;
        manual_reset  = 1'b0;
        log_ready_i   = 1'b0;
        tick(2);

        // Reset state
        checkOutput("rst state", 64'(state_o), 64'd0);
        checkOutput("rst latched", 64'(fault_latched_o), 64'd0);
        checkOutput("rst status", 64'(chan_status_o), 64'd0);
        checkOutput("rst log_valid", 64'(log_valid_o), 64'd0);
        checkOutput("rst log_count", 64'(log_count_o), 64'd0);
        checkOutput("rst log_data", 64'(log_data_o), 64'd0);
        checkOutput("rst overflow", 64'(log_overflow_o), 64'd0);
        checkOutput("rst warn_cnt", 64'(warning_count_o), 64'd0);
        checkOutput("rst fault_cnt", 64'(fault_count_o), 64'd0);
        rst = 1'b0;
        tick(1);

        // Debounce hysteresis on ch3 (masked so the FSM stays quiet)
        setSample(3, 12'd3000);
        applyStimulus(7);
        setSample(3, 12'd2048);
        applyStimulus(1);
        checkOutput("deb 7+clear", 64'(chan_status_o[3]), 64'd0);
        setSample(3, 12'd3000);
        applyStimulus(7);
        checkOutput("deb 7 of 8", 64'(chan_status_o[3]), 64'd0);
        applyStimulus(1);
        checkOutput("deb 8", 64'(chan_status_o[3]), 64'd1);
        setSample(3, 12'd2048);
        applyStimulus(15);
        setSample(3, 12'd3000);
        applyStimulus(1);
        checkOutput("deb 15 clear+raw", 64'(chan_status_o[3]), 64'd1);
        setSample(3, 12'd2048);
        applyStimulus(16);
        checkOutput("deb 16 clear", 64'(chan_status_o[3]), 64'd0);
        checkOutput("deb state", 64'(state_o), 64'd0);

        // Persist escalation on ch0 (under-threshold)
        setSample(0, 12'd100);
        applyStimulus(8);
        checkOutput("pers status", 64'(chan_status_o[0]), 64'd1);
        checkOutput("pers still normal", 64'(state_o), 64'd0);
        tick(1);
        pushExp(EVT_ENTER_WARN, 3'd0);
        exp_warn++;
        checkOutput("pers warn", 64'(state_o), 64'(ST_WARNING));
        checkOutput("pers log_valid", 64'(log_valid_o), 64'd1);
        checkOutput("pers log_count", 64'(log_count_o), 64'd1);
        checkOutput("pers warn_cnt", 64'(warning_count_o), 64'(exp_warn));
        tick(PERSIST - 1);
        checkOutput("pers warn at 49", 64'(state_o), 64'(ST_WARNING));
        tick(1);
        pushExp(EVT_ENTER_FAULT, 3'd0);
        exp_fault++;
        checkOutput("pers fault", 64'(state_o), 64'(ST_FAULT));
        checkOutput("pers latched", 64'(fault_latched_o), 64'd1);
        checkOutput("pers fault_cnt", 64'(fault_count_o), 64'(exp_fault));
        checkOutput("pers active_ch", 64'(active_ch_o), 64'd0);
        drainLog("pers log");
        if (popped.size() >= 2)
            checkOutput("pers ts delta", 64'(popped[1][LOG_W-1:CH_W+2] - popped[0][LOG_W-1:CH_W+2]), 64'(PERSIST));
        else
            checkOutput("pers ts pair", 64'(popped.size()), 64'd2);
        setSample(0, 12'd2048);
        applyStimulus(16);
        checkOutput("pers fault holds", 64'(state_o), 64'(ST_FAULT));
        manual_reset = 1'b1;
        tick(1);
        manual_reset = 1'b0;
        pushExp(EVT_MANUAL_RESET, 3'd0);
        checkOutput("mr normal", 64'(state_o), 64'd0);
        checkOutput("mr active_ch", 64'(active_ch_o), 64'd0);
        drainLog("mr log");

        // Priority and shutdown: ch2 and ch5, only ch5 may shut down
        shutdown_en = 8'b0010_0000;
        setSample(2, 12'd3000);
        setSample(5, 12'd3000);
        applyStimulus(8);
        tick(1);
        pushExp(EVT_ENTER_WARN, 3'd2);
        exp_warn++;
        tick(PERSIST);
        pushExp(EVT_ENTER_FAULT, 3'd2);
        exp_fault++;
        checkOutput("prio fault", 64'(state_o), 64'(ST_FAULT));
        checkOutput("prio active_ch", 64'(active_ch_o), 64'd2);
        tick(1);
        pushExp(EVT_ENTER_SHUTDOWN, 3'd5);
        checkOutput("prio shutdown", 64'(state_o), 64'(ST_SHUTDOWN));
        checkOutput("prio sd active_ch", 64'(active_ch_o), 64'd5);
        checkOutput("prio fault_cnt", 64'(fault_count_o), 64'(exp_fault));
        checkOutput("prio latched", 64'(fault_latched_o), 64'd1);
        setSample(2, 12'd2048);
        setSample(5, 12'd2048);
        applyStimulus(16);
        manual_reset = 1'b1;
        tick(1);
        manual_reset = 1'b0;
        pushExp(EVT_MANUAL_RESET, 3'd0);
        checkOutput("prio mr normal", 64'(state_o), 64'd0);
        drainLog("prio log");
        shutdown_en = 8'b0000_0000;

        // Decay: ch1 debounced while masked, then unmasking gates the FSM
        mask = 8'b0000_1010;
        setSample(1, 12'd3000);
        applyStimulus(8);
        checkOutput("decay status", 64'(chan_status_o[1]), 64'd1);
        mask = 8'b0000_1000;
        tick(1);
        pushExp(EVT_ENTER_WARN, 3'd1);
        exp_warn++;
        checkOutput("decay warn", 64'(state_o), 64'(ST_WARNING));
        tick(9);
        mask = 8'b0000_1010;
        tick(9);
        checkOutput("decay warn at 9", 64'(state_o), 64'(ST_WARNING));
        tick(1);
        checkOutput("decay normal at 10", 64'(state_o), 64'd0);
        checkOutput("decay fault_cnt", 64'(fault_count_o), 64'(exp_fault));
        checkOutput("decay warn_cnt", 64'(warning_count_o), 64'(exp_warn));

        // manual_reset on the edge FAULT would be entered
        mask = 8'b0000_1000;
        tick(1);
        pushExp(EVT_ENTER_WARN, 3'd1);
        exp_warn++;
        tick(PERSIST - 1);
        checkOutput("coll warn", 64'(state_o), 64'(ST_WARNING));
        manual_reset = 1'b1;
        tick(1);
        pushExp(EVT_MANUAL_RESET, 3'd0);
        checkOutput("coll normal", 64'(state_o), 64'd0);
        checkOutput("coll fault_cnt", 64'(fault_count_o), 64'(exp_fault));
        checkOutput("coll latched", 64'(fault_latched_o), 64'd0);
        manual_reset = 1'b0;
        mask = 8'b0000_1010;
        tick(1);
        checkOutput("coll stays normal", 64'(state_o), 64'd0);
        drainLog("coll log");

        // FIFO overflow: 17 events with no consumer
        for (int i = 0; i < 8; i++) begin
            mask = 8'b0000_1000;
            manual_reset = 1'b0;
            tick(1);
            pushExp(EVT_ENTER_WARN, 3'd1);
            exp_warn++;
            manual_reset = 1'b1;
            tick(1);
            pushExp(EVT_MANUAL_RESET, 3'd0);
        end
        manual_reset = 1'b0;
        tick(1);
        exp_warn++;
        mask = 8'b0000_1010;
        tick(1);
        checkOutput("ovf count", 64'(log_count_o), 64'd16);
        checkOutput("ovf flag", 64'(log_overflow_o), 64'd1);
        checkOutput("ovf state", 64'(state_o), 64'd0);
        checkOutput("ovf warn_cnt", 64'(warning_count_o), 64'(exp_warn));
        drainLog("ovf log");
        checkOutput("ovf sticky", 64'(log_overflow_o), 64'd1);

        // Refill, then push into a full FIFO while popping
        for (int i = 0; i < 8; i++) begin
            mask = 8'b0000_1000;
            manual_reset = 1'b0;
            tick(1);
            pushExp(EVT_ENTER_WARN, 3'd1);
            manual_reset = 1'b1;
            tick(1);
            pushExp(EVT_MANUAL_RESET, 3'd0);
        end
        manual_reset = 1'b0;
        checkOutput("full count", 64'(log_count_o), 64'd16);
        log_ready_i = 1'b1;
        head = sb_q.pop_front();
        checkOutput("full pop head", 64'(log_data_o), 64'(head));
        tick(1);
        pushExp(EVT_ENTER_WARN, 3'd1);
        log_ready_i = 1'b0;
        mask = 8'b0000_1010;
        checkOutput("full push+pop count", 64'(log_count_o), 64'd16);
        tick(1);
        drainLog("full log");

        // Asynchronous reset mid-stream
        mask = 8'b0000_1000;
        tick(1);
        manual_reset = 1'b1;
        tick(1);
        manual_reset = 1'b0;
        mask = 8'b0000_1010;
        checkOutput("pre-rst count", 64'(log_count_o), 64'd2);
        rst = 1'b1;
        #2;
        checkOutput("mid-rst count", 64'(log_count_o), 64'd0);
        checkOutput("mid-rst valid", 64'(log_valid_o), 64'd0);
        checkOutput("mid-rst overflow", 64'(log_overflow_o), 64'd0);
        checkOutput("mid-rst warn_cnt", 64'(warning_count_o), 64'd0);
        checkOutput("mid-rst status", 64'(chan_status_o), 64'd0);
        sb_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        checkOutput("post-rst state", 64'(state_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
